score_bcd_ctrl: RTL and testbench

- Sequential score keeper and BCD scheduler for the score/hi-score overlay.
- Holds the current score and the high score in binary.
- Shares one serial double-dabble converter between two requesters, the score and the hi-score, and presents registered BCD digits to the segment renderers.
- Replaces per-pixel-path modulo/divide logic with a 16-cycle, one-at-a-time conversion.

---
 rtl/score_pkg.sv | 39 +++
 rtl/bcd_dd_serial.sv | 53 +++++
 rtl/score_bcd_ctrl.sv | 164 ++++++++++++++++
 tb/tb_score_bcd_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared definitions for the score / hi-score BCD display controller.
// Holds the score width and saturation limit, the converter geometry, the
// conversion FSM encoding and the converter source select encoding.
// It also holds the double-dabble nibble adjust used by the serial converter.
package score_pkg;

   localparam int SCORE_W   = 14;
   localparam int SCORE_MAX = 9999;
   localparam int BCD_W     = 16;
   localparam int CONV_CYC  = SCORE_W;
   localparam int DD_W      = BCD_W + SCORE_W;
   localparam int CNT_W     = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      STORE = 2'd3
   } conv_state_t;

   typedef enum logic {
      SEL_SCORE = 1'b0,
      SEL_HI    = 1'b1
   } src_sel_t;

   // Any nibble of 5 or more gets 3 added, so the next left shift
   // carries correctly into the following decimal digit.
   function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] d);
      logic [BCD_W-1:0] r;
      r = d;
      for (int i = 0; i < BCD_W / 4; i++) begin
         if (d[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = d[4*i +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_dd_serial.sv
// Serial double-dabble binary to BCD converter.
// A load pulse captures din and starts the conversion. The converter then
// performs CONV_CYC adjust-and-shift steps, one per clock. done is high
// during the last step. bcd holds the finished digits from the cycle after
// done until the next load.
//   clk   : system clock
//   reset : synchronous, active-high
//   load  : start a conversion of din
//   din   : binary value to convert (SCORE_W bits)
//   done  : high during the final shift cycle
//   bcd   : {thou,hund,ten,unit}, 4 bits each
module bcd_dd_serial
   import score_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [SCORE_W-1:0] din,
   output logic               done,
   output logic [BCD_W-1:0]   bcd
);

   logic [DD_W-1:0]  sreg;
   logic [DD_W-1:0]  sreg_adj;
   logic [CNT_W-1:0] cnt;
   logic             active;

   always_comb begin
      sreg_adj = {bcd_adjust(sreg[DD_W-1:SCORE_W]), sreg[SCORE_W-1:0]};
   end

   assign done = active && (cnt == CNT_W'(CONV_CYC - 1));
   assign bcd  = sreg[DD_W-1:SCORE_W];

   always_ff @(posedge clk) begin
      if (reset) begin
         sreg   <= '0;
         cnt    <= '0;
         active <= 1'b0;
      end else if (load) begin
         sreg   <= {{BCD_W{1'b0}}, din};
         cnt    <= '0;
         active <= 1'b1;
      end else if (active) begin
         sreg <= sreg_adj << 1;
         cnt  <= cnt + CNT_W'(1);
         if (done) begin
            active <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/score_bcd_ctrl.sv
// Score keeper and BCD scheduler for the score / hi-score overlay.
// Keeps the score and the hi-score in binary. One serial converter is shared
// between both values, with the hi-score taking priority. Each value owns a
// dirty flag, and a conversion is only started from IDLE.
//   clk        : system clock
//   reset      : synchronous, active-high
//   game_start : pulse, clear score and start playing
//   game_over  : pulse, stop playing and update the hi-score
//   score_tick : pulse, add one to the score while playing
//   playing    : a game is in progress
//   score_bin  : current score, binary
//   hi_bin     : high score, binary
//   score_bcd  : score digits {thou,hund,ten,unit}
//   hi_bcd     : hi-score digits {thou,hund,ten,unit}
//   new_hi     : the last game beat the hi-score
//   busy       : converter active (LOAD/SHIFT/STORE)
//
// state | meaning
// IDLE  | wait for a dirty flag, then grant (hi before score)
// LOAD  | snapshot selected value into converter, clear its dirty flag
// SHIFT | CONV_CYC double-dabble steps
// STORE | write all digits of the selected output in one edge
module score_bcd_ctrl
   import score_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               game_start,
   input  logic               game_over,
   input  logic               score_tick,
   output logic               playing,
   output logic [SCORE_W-1:0] score_bin,
   output logic [SCORE_W-1:0] hi_bin,
   output logic [BCD_W-1:0]   score_bcd,
   output logic [BCD_W-1:0]   hi_bcd,
   output logic               new_hi,
   output logic               busy
);

   conv_state_t        state_q, state_d;
   src_sel_t           sel_q, sel_d;
   logic               score_dirty, hi_dirty;
   logic [SCORE_W-1:0] score_next;
   logic [SCORE_W-1:0] snap;
   logic               dd_load, dd_done;
   logic [BCD_W-1:0]   dd_bcd;

   always_comb begin
      score_next = score_bin;
      if (score_tick && (score_bin != SCORE_W'(SCORE_MAX))) begin
         score_next = score_bin + SCORE_W'(1);
      end
   end

   assign snap = (sel_q == SEL_HI) ? hi_bin : score_bin;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sel_q   <= SEL_SCORE;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      dd_load = 1'b0;
      busy    = 1'b0;
      case (state_q)
         IDLE: begin
            if (hi_dirty) begin
               sel_d   = SEL_HI;
               state_d = LOAD;
            end else if (score_dirty) begin
               sel_d   = SEL_SCORE;
               state_d = LOAD;
            end
         end
         LOAD: begin
            busy    = 1'b1;
            dd_load = 1'b1;
            state_d = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (dd_done) begin
               state_d = STORE;
            end
         end
         STORE: begin
            busy    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // The LOAD clear comes first so an update landing in the same cycle
   // re-sets the flag: the snapshot holds the old value, and the new value
   // must be converted afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         score_bin   <= '0;
         hi_bin      <= '0;
         playing     <= 1'b0;
         new_hi      <= 1'b0;
         score_dirty <= 1'b0;
         hi_dirty    <= 1'b0;
      end else begin
         if (state_q == LOAD) begin
            if (sel_q == SEL_HI) begin
               hi_dirty <= 1'b0;
            end else begin
               score_dirty <= 1'b0;
            end
         end
         if (game_start) begin
            score_bin   <= '0;
            playing     <= 1'b1;
            new_hi      <= 1'b0;
            score_dirty <= 1'b1;
         end else if (playing) begin
            score_bin <= score_next;
            if (score_next != score_bin) begin
               score_dirty <= 1'b1;
            end
            if (game_over) begin
               playing <= 1'b0;
               if (score_next > hi_bin) begin
                  hi_bin   <= score_next;
                  new_hi   <= 1'b1;
                  hi_dirty <= 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         score_bcd <= '0;
         hi_bcd    <= '0;
      end else if (state_q == STORE) begin
         if (sel_q == SEL_HI) begin
            hi_bcd <= dd_bcd;
         end else begin
            score_bcd <= dd_bcd;
         end
      end
   end

   bcd_dd_serial u_dd (
      .clk   (clk),
      .reset (reset),
      .load  (dd_load),
      .din   (snap),
      .done  (dd_done),
      .bcd   (dd_bcd)
   );

endmodule

// File: tb/tb_score_bcd_ctrl.sv
// Testbench for score_bcd_ctrl.
// A reference model tracks score, hi-score and game state with plain integer
// arithmetic, and pushes every new value into per-output queues.
// At each conversion completion (a falling edge of busy), a monitor requires
// each displayed digit set to be a pending queued value, computed with
// divide/modulo, and requires the conversion to have lasted 16 busy cycles.
module tb_score_bcd_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        game_start = 1'b0;
   logic        game_over = 1'b0;
   logic        score_tick = 1'b0;
   logic        playing, new_hi, busy;
   logic [13:0] score_bin, hi_bin;
   logic [15:0] score_bcd, hi_bcd;

   always #5 clk = ~clk;

   score_bcd_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .game_start (game_start),
      .game_over  (game_over),
      .score_tick (score_tick),
      .playing    (playing),
      .score_bin  (score_bin),
      .hi_bin     (hi_bin),
      .score_bcd  (score_bcd),
      .hi_bcd     (hi_bcd),
      .new_hi     (new_hi),
      .busy       (busy)
   );

   int n_chk = 0;
   int n_err = 0;

   int m_score = 0, m_hi = 0, m_nxt = 0;
   bit m_play = 0, m_new = 0, m_rst = 0, armed = 0;
   int sq[$];
   int hq[$];
   int bcnt = 0;
   bit bprev = 0;
   int idx;

   function automatic int to_bcd(input int v);
      return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: spec rules on integers, one update per clock.
   always @(posedge clk) begin
      m_rst = 0;
      if (reset) begin
         m_score = 0; m_hi = 0; m_play = 0; m_new = 0;
         sq.delete(); hq.delete();
         sq.push_back(0); hq.push_back(0);
         m_rst = 1; armed = 1;
      end else if (game_start) begin
         m_score = 0; m_play = 1; m_new = 0;
         sq.push_back(0);
      end else if (m_play) begin
         m_nxt = (score_tick && m_score < 9999) ? m_score + 1 : m_score;
         if (m_nxt != m_score) begin
            m_score = m_nxt;
            sq.push_back(m_nxt);
         end
         if (game_over) begin
            m_play = 0;
            if (m_nxt > m_hi) begin
               m_hi = m_nxt; m_new = 1;
               hq.push_back(m_nxt);
            end
         end
      end
   end

   // Monitor / scoreboard.
   always @(negedge clk) begin
      if (armed) begin
         chk("playing", int'(playing), int'(m_play));
         chk("score_bin", int'(score_bin), m_score);
         chk("hi_bin", int'(hi_bin), m_hi);
         chk("new_hi", int'(new_hi), int'(m_new));
         if (m_rst) begin
            chk("rst_busy", int'(busy), 0);
            chk("rst_score_bcd", int'(score_bcd), 0);
            chk("rst_hi_bcd", int'(hi_bcd), 0);
            bcnt = 0;
            bprev = 0;
         end else begin
            if (busy) begin
               bcnt++;
            end else if (bprev) begin
               chk("conv_len", bcnt, 16);
               bcnt = 0;
               idx = -1;
               for (int i = 0; i < sq.size(); i++)
                  if (idx < 0 && to_bcd(sq[i]) == int'(score_bcd)) idx = i;
               n_chk++;
               if (idx < 0) begin
                  n_err++;
                  $display("FAIL sb_score_bcd: got 0x%0h, expected a pending value, oldest 0x%0h at %0t",
                           score_bcd, to_bcd(sq[0]), $time);
               end else begin
                  repeat (idx) void'(sq.pop_front());
               end
               idx = -1;
               for (int i = 0; i < hq.size(); i++)
                  if (idx < 0 && to_bcd(hq[i]) == int'(hi_bcd)) idx = i;
               n_chk++;
               if (idx < 0) begin
                  n_err++;
                  $display("FAIL sb_hi_bcd: got 0x%0h, expected a pending value, oldest 0x%0h at %0t",
                           hi_bcd, to_bcd(hq[0]), $time);
               end else begin
                  repeat (idx) void'(hq.pop_front());
               end
            end
            bprev = busy;
         end
      end
   end

   task automatic step(input bit gs, input bit go, input bit tk);
      game_start = gs; game_over = go; score_tick = tk;
      @(posedge clk); #1;
      game_start = 0; game_over = 0; score_tick = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0);
   endtask

   task automatic settle();
      idle(60);
      chk("settle_busy", int'(busy), 0);
      chk("settle_score_bcd", int'(score_bcd), to_bcd(m_score));
      chk("settle_hi_bcd", int'(hi_bcd), to_bcd(m_hi));
   endtask

   task automatic wait_conv(input string name);
      int t;
      bit seen;
      t = 0;
      while (!busy && t < 40) begin @(negedge clk); t++; end
      seen = busy;
      while (busy && t < 80) begin @(negedge clk); t++; end
      chk(name, int'(seen && !busy), 1);
   endtask

   task automatic do_reset();
      reset = 1;
      idle(2);
      reset = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      bit gs, go, tk;
      int r;

      // Reset, then first game start converts a zero score.
      idle(3);
      reset = 0;
      idle(1);
      chk("reset_busy", int'(busy), 0);
      chk("reset_score_bcd", int'(score_bcd), 0);
      step(1, 0, 0);
      chk("start_playing", int'(playing), 1);
      idle(17);
      chk("start_bcd", int'(score_bcd), 16'h0000);
      chk("start_busy_done", int'(busy), 0);

      // 37 spaced ticks.
      for (int i = 0; i < 37; i++) begin
         step(0, 0, 1);
         idle(19);
      end
      chk("tick37_bin", int'(score_bin), 37);
      chk("tick37_bcd", int'(score_bcd), 16'h0037);

      // Reach 125, game over with hi 0.
      for (int i = 0; i < 88; i++) step(0, 0, 1);
      settle();
      step(0, 1, 0);
      chk("go125_playing", int'(playing), 0);
      chk("go125_hi_bin", int'(hi_bin), 125);
      chk("go125_new_hi", int'(new_hi), 1);
      wait_conv("go125_conv");
      chk("go125_hi_bcd", int'(hi_bcd), 16'h0125);

      // Game scoring 40 does not beat 125.
      step(1, 0, 0);
      chk("g40_new_hi_clr", int'(new_hi), 0);
      for (int i = 0; i < 40; i++) step(0, 0, 1);
      settle();
      step(0, 1, 0);
      chk("g40_hi_bin", int'(hi_bin), 125);
      chk("g40_new_hi", int'(new_hi), 0);

      // game_start and game_over together.
      step(1, 1, 0);
      chk("startover_playing", int'(playing), 1);
      chk("startover_score", int'(score_bin), 0);
      chk("startover_hi", int'(hi_bin), 125);
      settle();

      // Ticks every 2 cycles while the converter is busy.
      for (int i = 0; i < 30; i++) begin
         step(0, 0, 1);
         step(0, 0, 0);
      end
      idle(32);
      chk("fast_bin", int'(score_bin), 30);
      chk("fast_bcd", int'(score_bcd), 16'h0030);
      chk("fast_busy", int'(busy), 0);

      // Hi 99, then tick and game_over together at 99.
      do_reset();
      step(1, 0, 0);
      for (int i = 0; i < 99; i++) step(0, 0, 1);
      step(0, 1, 0);
      settle();
      step(1, 0, 0);
      for (int i = 0; i < 99; i++) step(0, 0, 1);
      settle();
      step(0, 1, 1);
      chk("prio_score_bin", int'(score_bin), 100);
      chk("prio_hi_bin", int'(hi_bin), 100);
      chk("prio_new_hi", int'(new_hi), 1);
      wait_conv("prio_conv");
      chk("prio_hi_first", int'(hi_bcd), 16'h0100);
      chk("prio_score_later", int'(score_bcd), 16'h0099);
      settle();

      // Reset in the middle of SHIFT.
      step(1, 0, 0);
      idle(6);
      chk("midshift_busy", int'(busy), 1);
      reset = 1;
      step(0, 0, 0);
      reset = 0;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_score_bcd", int'(score_bcd), 0);
      chk("midrst_hi_bcd", int'(hi_bcd), 0);
      settle();

      // Saturation at 9999.
      step(1, 0, 0);
      for (int i = 0; i < 9998; i++) step(0, 0, 1);
      chk("sat_9998", int'(score_bin), 9998);
      for (int i = 0; i < 3; i++) step(0, 0, 1);
      chk("sat_bin", int'(score_bin), 9999);
      settle();
      chk("sat_bcd", int'(score_bcd), 16'h9999);
      for (int i = 0; i < 40; i++) begin
         step(0, 0, 1);
         chk("sat_no_conv", int'(busy), 0);
      end
      step(0, 1, 0);
      chk("sat_hi_bin", int'(hi_bin), 9999);
      settle();
      chk("sat_hi_bcd", int'(hi_bcd), 16'h9999);

      // Random traffic.
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         r  = $urandom_range(0, 199);
         gs = (r < 3);
         go = (r >= 3 && r < 5);
         tk = ($urandom_range(0, 1) == 1);
         reset = ($urandom_range(0, 599) == 0);
         step(gs, go, tk);
         reset = 0;
      end
      settle();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
